// File: rtl/uart_rx_char.sv
// uart_rx_char: 8N1 UART receiver feeding the display character register.
// Holds the last correctly framed byte on char_out. char_valid pulses for one
// clock when a new byte lands. frame_err pulses for one clock when the stop bit
// is sampled low. A held-low line (break) is absorbed in WAIT_HI rather than
// being decoded as a stream of 0x00 frames.
module uart_rx_char #(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned BAUD     = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] char_out,
  output logic       char_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned CPB  = CLK_FREQ / BAUD;
  localparam int unsigned HALF = CPB / 2;
  localparam int unsigned CW   = (CPB > 1) ? $clog2(CPB) : 1;

  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
  localparam logic [CW-1:0] CPB_M1  = CW'(CPB - 1);
  localparam logic [7:0]    IDLE_CHAR = 8'h20;

  // Too few clocks per bit leaves no room for mid-bit sampling.
  if (CPB < 8) begin : g_cpb_check
    $error("uart_rx_char: CLK_FREQ/BAUD must be at least 8");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HI
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [1:0]    sync;
  logic          rx_s;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic [2:0]    bit_idx;
  logic [2:0]    bit_idx_n;
  logic [7:0]    shreg;
  logic [7:0]    shreg_n;
  logic [7:0]    char_n;
  logic          valid_n;
  logic          err_n;

  assign rx_s = sync[1];

  // State, datapath and registered strobes; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sync       <= '1;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      char_out   <= IDLE_CHAR;
      char_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_n;
      sync       <= {sync[0], rx};
      cnt        <= cnt_n;
      bit_idx    <= bit_idx_n;
      shreg      <= shreg_n;
      char_out   <= char_n;
      char_valid <= valid_n;
      frame_err  <= err_n;
    end
  end

  // Next-state and next-datapath decode, all decisions on the synchronised rx_s.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    char_n    = char_out;
    valid_n   = 1'b0;
    err_n     = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (!rx_s) begin
          state_n = START;
        end
      end
      START: begin
        if (cnt == HALF_M1) begin
          cnt_n = '0;
          if (!rx_s) begin
            state_n   = DATA;
            bit_idx_n = '0;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      DATA: begin
        if (cnt == CPB_M1) begin
          cnt_n            = '0;
          shreg_n[bit_idx] = rx_s;
          if (bit_idx == 3'd7) begin
            state_n = STOP;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      STOP: begin
        if (cnt == CPB_M1) begin
          cnt_n = '0;
          if (rx_s) begin
            char_n  = shreg;
            valid_n = 1'b1;
            state_n = IDLE;
          end else begin
            err_n   = 1'b1;
            state_n = WAIT_HI;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      WAIT_HI: begin
        cnt_n = '0;
        if (rx_s) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Status output decode.
  always_comb begin
    busy = (state != IDLE);
  end

endmodule

// File: tb/tb_uart_rx_char.sv
// tb_uart_rx_char: directed frames at CPB=16 against hand-computed results.
module tb_uart_rx_char;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] char_out;
  logic       char_valid;
  logic       frame_err;
  logic       busy;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int          cyc = 0;
  int          valid_cnt = 0;
  int          err_cnt = 0;
  int          both_cnt = 0;
  int          last_valid_cyc = 0;
  logic [7:0]  cap[$];

  uart_rx_char #(
    .CLK_FREQ(1_600_000),
    .BAUD    (100_000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .char_out  (char_out),
    .char_valid(char_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Cycle counter plus strobe monitor sampled 2 time units after each edge.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    #2;
    if (char_valid) begin
      valid_cnt++;
      last_valid_cyc = cyc;
      cap.push_back(char_out);
    end
    if (frame_err) err_cnt++;
    if (char_valid && frame_err) both_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drives start, 8 data bits LSB first, stop. rst_bit >= 0 pulses reset
  // half-way through that data bit and abandons the frame with the line idle.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int rst_bit);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      if (i == rst_bit) begin
        repeat (8) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rx  = 1'b1;
        return;
      end
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
  endtask

  initial begin
    int v0, e0, s0, lat, base;

    // 1: reset and idle line
    rst = 1'b1;
    rx  = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    check("reset_char", 32'(char_out), 32'h20);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_valid_cnt", 32'(valid_cnt), 32'd0);
    check("reset_err_cnt", 32'(err_cnt), 32'd0);

    // 2: good frame 0x41, latency 2+8+144 +/-1
    v0 = valid_cnt; e0 = err_cnt; s0 = cyc;
    send_frame(8'h41, 1'b1, -1);
    repeat (4) @(negedge clk);
    lat = last_valid_cyc - s0;
    check("f41_valid_cnt", 32'(valid_cnt - v0), 32'd1);
    check("f41_char", 32'(char_out), 32'h41);
    check("f41_err_cnt", 32'(err_cnt - e0), 32'd0);
    check("f41_latency_ok", 32'(lat >= 153 && lat <= 155), 32'd1);
    check("f41_busy", 32'(busy), 32'd0);

    // 3: 4-cycle glitch rejected
    v0 = valid_cnt; e0 = err_cnt;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_valid_cnt", 32'(valid_cnt - v0), 32'd0);
    check("glitch_err_cnt", 32'(err_cnt - e0), 32'd0);
    check("glitch_char", 32'(char_out), 32'h41);
    check("glitch_busy", 32'(busy), 32'd0);

    // 4: 0x55 with low stop bit, line held low 40 more cycles (break)
    v0 = valid_cnt; e0 = err_cnt;
    send_frame(8'h55, 1'b0, -1);
    repeat (40) @(negedge clk);
    check("break_busy_low", 32'(busy), 32'd1);
    check("break_err_cnt_low", 32'(err_cnt - e0), 32'd1);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    check("break_busy_idle", 32'(busy), 32'd0);
    check("break_err_cnt", 32'(err_cnt - e0), 32'd1);
    check("break_valid_cnt", 32'(valid_cnt - v0), 32'd0);
    check("break_char", 32'(char_out), 32'h41);

    // 5: back-to-back 0x48, 0x49
    v0 = valid_cnt; base = cap.size();
    send_frame(8'h48, 1'b1, -1);
    send_frame(8'h49, 1'b1, -1);
    repeat (20) @(negedge clk);
    check("b2b_valid_cnt", 32'(valid_cnt - v0), 32'd2);
    if (cap.size() >= base + 2) begin
      check("b2b_first", 32'(cap[base]), 32'h48);
      check("b2b_second", 32'(cap[base+1]), 32'h49);
    end else begin
      check("b2b_captures", 32'(cap.size() - base), 32'd2);
    end
    check("b2b_char", 32'(char_out), 32'h49);

    // 6: reset during data bit 4 of 0x7A, then 0x31
    v0 = valid_cnt; e0 = err_cnt;
    send_frame(8'h7A, 1'b1, 4);
    check("abort_char", 32'(char_out), 32'h20);
    check("abort_busy", 32'(busy), 32'd0);
    repeat (200) @(negedge clk);
    check("abort_valid_cnt", 32'(valid_cnt - v0), 32'd0);
    check("abort_err_cnt", 32'(err_cnt - e0), 32'd0);
    check("abort_char_hold", 32'(char_out), 32'h20);
    v0 = valid_cnt;
    send_frame(8'h31, 1'b1, -1);
    repeat (4) @(negedge clk);
    check("after_abort_valid_cnt", 32'(valid_cnt - v0), 32'd1);
    check("after_abort_char", 32'(char_out), 32'h31);

    check("never_both_strobes", 32'(both_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
